pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined WIDTH-bit adder/subtractor with a valid/ready handshake. It generalises the registered single-bit full adder to a multi-bit carry chain split into STAGES registered segments, with a runtime add/subtract mode, signed-overflow detection and whole-pipeline back-pressure. It sits in the datapath library as the standard arithmetic primitive for the formal-verification flow.

## Interface
- WIDTH, 8: operand and result width in bits; must be ≥ 2 and divisible by STAGES.
- STAGES, 2: number of pipeline segments and the latency in cycles; must be ≥ 1. SEG = WIDTH/STAGES bits per segment.
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset; synchronous, active-low.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- carry_in  in  1  carry into bit 0.
- sub  in  1  0: add, 1: invert B (subtract).
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result this cycle.
- sum  out  WIDTH  result bits.
- carry_out  out  1  carry out of bit WIDTH-1.
- overflow  out  1  two's-complement overflow.

## Operation
- Effective operand: b_eff = sub ? ~b : b. Result: {carry_out, sum} = a + b_eff + carry_in, computed modulo 2^(WIDTH+1). Pure subtraction a-b requires sub=1 and carry_in=1. Chained subtraction with a borrow uses carry_in = ~borrow.
- overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]).
- Segment k (k = 0..STAGES-1) adds bits [k*SEG +: SEG] in pipeline stage k. It uses the carry registered from segment k-1, or carry_in for k = 0.
- Upper operand slices are skewed: the slice for segment k is delayed k stages alongside the beat. Lower result slices are de-skewed: a slice produced in stage k is delayed STAGES-1-k further stages. All slices of one beat therefore emerge together.
- Each stage holds one valid bit. A beat never mixes with bits of another beat.
- advance = !out_valid || out_ready. When advance=1, every stage shifts forward one position, and stage 0 loads the input if in_valid, otherwise a bubble with valid=0.
- in_ready = advance. This is purely combinational from out_valid and out_ready, with no dependence on in_valid.
- When advance=0, all stages, including the valid bits, hold their contents. Bubbles are not squeezed out during a stall.
- Reset (rstn=0 at a rising edge): all valid bits become 0 and all data, carry and skew registers become 0. In-flight beats are discarded. Reset takes priority over advance.

## Timing
- Reset values: out_valid=0, sum=0, carry_out=0, overflow=0. in_ready=1 after reset because out_valid=0.
- Latency: a beat accepted at rising edge t (in_valid && in_ready) appears with out_valid=1 immediately after edge t+STAGES-1, assuming no stall. With STAGES=1 the result is registered on the accepting edge.
- Throughput: one beat per cycle while out_ready=1.
- sum, carry_out and overflow are registered outputs, stable while out_valid=1 && out_ready=0.
- Simultaneous out_ready=1 and in_valid=1 with a full pipeline: one beat is retired and one accepted on the same edge, so there is no lost cycle.
- When rstn is deasserted, the first beat can be accepted on the very next edge.
- Inputs a, b, sub and carry_in are sampled only when in_valid && in_ready. They are don't-care otherwise.

## Test plan
- WIDTH=8, STAGES=2, out_ready=1: a=8'hFF, b=8'h01, sub=0, cin=0 -> 2 edges later out_valid=1, sum=8'h00, carry_out=1, overflow=0.
- a=8'h7F, b=8'h01, sub=0, cin=0 -> sum=8'h80, carry_out=0, overflow=1. Then a=8'h80, b=8'h01, sub=1, cin=1 -> sum=8'h7F, carry_out=1, overflow=1.
- a=8'h05, b=8'h07, sub=1, cin=1 -> sum=8'hFE, carry_out=0, overflow=0. Carry crossing the segment boundary: a=8'h0F, b=8'h01, sub=0 -> sum=8'h10.
- Back-to-back: 4 consecutive beats (00+01, 10+20, F0+20, 7F+7F) -> 4 consecutive out_valid cycles in order, with sums 01, 30, 10 (cout=1), FE (ovf=1).
- Stall: hold out_ready=0 for 3 cycles with a full pipeline -> in_ready=0, sum held constant. Release -> beats drain in order with none lost or duplicated.
- Reset mid-flight: accept 2 beats, then assert rstn=0 for 1 edge -> out_valid=0, sum=0 and no stale beat ever emerges. Repeat the whole suite at STAGES=1 and at WIDTH=16, STAGES=4.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor with valid/ready handshake.
// The carry chain is cut into STAGES segments of SEG bits. Each stage owns
// a WIDTH-bit work vector. Bits below the current segment already hold the
// result, and bits above it still hold operand A. Each stage therefore
// de-skews the finished slices and skews the pending A slices with no
// separate registers. The pending B slices shrink by one segment per stage.
module pipelined_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);
  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic             advance;
  logic [WIDTH-1:0] b_eff;

  assign b_eff = sub ? ~b : b;

  // Skewed upper slices of the effective B operand. Stage k keeps only the
  // slices that later segments still need.
  for (genvar k = 0; k < STAGES - 1; k++) begin : g_b
    localparam int UW = WIDTH - (k + 1) * SEG;
    logic [UW-1:0] b_d, b_q;

    if (k == 0) begin : g_src
      assign b_d = b_eff[WIDTH-1:SEG];
    end else begin : g_src
      assign b_d = g_b[k-1].b_q[UW+SEG-1:SEG];
    end

    // B skew register: cleared on reset, frozen during a stall
    always_ff @(posedge clk) begin
      if (!rstn)        b_q <= '0;
      else if (advance) b_q <= b_d;
    end
  end

  // One carry segment per stage. The carry and valid bit travel with the beat.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [WIDTH-1:0] ar_in, ar_d, ar_q;
    logic [SEG-1:0]   bs;
    logic             ci, c_d, c_q, v_d, v_q;
    logic [SEG:0]     seg_sum;

    if (k == 0) begin : g_src
      assign ar_in = a;
      assign bs    = b_eff[SEG-1:0];
      assign ci    = carry_in;
      assign v_d   = in_valid;
    end else begin : g_src
      assign ar_in = g_stg[k-1].ar_q;
      assign bs    = g_b[k-1].b_q[SEG-1:0];
      assign ci    = g_stg[k-1].c_q;
      assign v_d   = g_stg[k-1].v_q;
    end

    assign seg_sum = {1'b0, ar_in[k*SEG +: SEG]} + {1'b0, bs} + {{SEG{1'b0}}, ci};
    assign c_d     = seg_sum[SEG];

    // Splice this segment's result over the A slice it consumed
    always_comb begin
      ar_d                 = ar_in;
      ar_d[k*SEG +: SEG]   = seg_sum[SEG-1:0];
    end

    // Stage register: reset wins, otherwise shift only when the pipe advances
    always_ff @(posedge clk) begin
      if (!rstn) begin
        ar_q <= '0;
        c_q  <= 1'b0;
        v_q  <= 1'b0;
      end else if (advance) begin
        ar_q <= ar_d;
        c_q  <= c_d;
        v_q  <= v_d;
      end
    end
  end

  // Overflow needs A's and B's sign bits. Both are still available at the
  // last stage, where A's MSB has not yet been overwritten.
  logic ovf_d, ovf_q;
  assign ovf_d = (g_stg[LAST].ar_in[WIDTH-1] == g_stg[LAST].bs[SEG-1]) &&
                 (g_stg[LAST].seg_sum[SEG-1] != g_stg[LAST].ar_in[WIDTH-1]);

  // Registered overflow flag, aligned with the last stage
  always_ff @(posedge clk) begin
    if (!rstn)        ovf_q <= 1'b0;
    else if (advance) ovf_q <= ovf_d;
  end

  assign out_valid = g_stg[LAST].v_q;
  assign sum       = g_stg[LAST].ar_q;
  assign carry_out = g_stg[LAST].c_q;
  assign overflow  = ovf_q;
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder. It runs one suite against three
// instances: W8/S2, W8/S1 and W16/S4. cfg selects the instance under test.
// The other instances see in_valid=0.
module tb_pipelined_adder;
  logic        clk = 1'b0;
  logic        rstn, in_valid, out_ready, sub, carry_in;
  logic [15:0] a, b;
  logic [1:0]  cfg;
  int          S, tests, fails;

  logic [2:0]  ov, ir, co, of, iv;
  logic [7:0]  s0, s1;
  logic [15:0] s2;
  logic        o_valid, o_ready, o_cout, o_ovf;
  logic [15:0] o_sum;

  typedef struct packed {
    logic [15:0] a; logic [15:0] b; logic sub; logic cin;
    logic [15:0] s; logic c; logic o;
  } vec_t;
  vec_t V [10];

  always #5 clk = ~clk;

  assign iv[0] = in_valid && (cfg == 2'd0);
  assign iv[1] = in_valid && (cfg == 2'd1);
  assign iv[2] = in_valid && (cfg == 2'd2);

  pipelined_adder #(.WIDTH(8), .STAGES(2)) u0 (
    .clk(clk), .rstn(rstn), .in_valid(iv[0]), .in_ready(ir[0]), .a(a[7:0]), .b(b[7:0]),
    .carry_in(carry_in), .sub(sub), .out_valid(ov[0]), .out_ready(out_ready),
    .sum(s0), .carry_out(co[0]), .overflow(of[0]));
  pipelined_adder #(.WIDTH(8), .STAGES(1)) u1 (
    .clk(clk), .rstn(rstn), .in_valid(iv[1]), .in_ready(ir[1]), .a(a[7:0]), .b(b[7:0]),
    .carry_in(carry_in), .sub(sub), .out_valid(ov[1]), .out_ready(out_ready),
    .sum(s1), .carry_out(co[1]), .overflow(of[1]));
  pipelined_adder #(.WIDTH(16), .STAGES(4)) u2 (
    .clk(clk), .rstn(rstn), .in_valid(iv[2]), .in_ready(ir[2]), .a(a), .b(b),
    .carry_in(carry_in), .sub(sub), .out_valid(ov[2]), .out_ready(out_ready),
    .sum(s2), .carry_out(co[2]), .overflow(of[2]));

  always_comb begin
    o_valid = ov[0]; o_ready = ir[0]; o_cout = co[0]; o_ovf = of[0]; o_sum = {8'h00, s0};
    case (cfg)
      2'd1: begin o_valid = ov[1]; o_ready = ir[1]; o_cout = co[1]; o_ovf = of[1]; o_sum = {8'h00, s1}; end
      2'd2: begin o_valid = ov[2]; o_ready = ir[2]; o_cout = co[2]; o_ovf = of[2]; o_sum = s2; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cfg%0d: observed %0h expected %0h", tag, cfg, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input int i);
    chk({tag, ".sum"},  32'(o_sum),  32'(V[i].s));
    chk({tag, ".cout"}, 32'(o_cout), 32'(V[i].c));
    chk({tag, ".ovf"},  32'(o_ovf),  32'(V[i].o));
  endtask

  task automatic drive(input int i);
    a = V[i].a; b = V[i].b; sub = V[i].sub; carry_in = V[i].cin;
  endtask

  // Vectors 0..5 are single beats and 6..9 are back-to-back. Expected values are hand-computed.
  task automatic load(input bit wide);
    if (!wide) begin
      V[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      V[1] = '{16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1};
      V[2] = '{16'h0080, 16'h0001, 1'b1, 1'b1, 16'h007F, 1'b1, 1'b1};
      V[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'h00FE, 1'b0, 1'b0};
      V[4] = '{16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0};
      V[5] = '{16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0};
      V[6] = '{16'h0000, 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0};
      V[7] = '{16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0};
      V[8] = '{16'h00F0, 16'h0020, 1'b0, 1'b0, 16'h0010, 1'b1, 1'b0};
      V[9] = '{16'h007F, 16'h007F, 1'b0, 1'b0, 16'h00FE, 1'b0, 1'b1};
    end else begin
      V[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      V[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      V[2] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      V[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      V[4] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
      V[5] = '{16'h1234, 16'h0F0F, 1'b0, 1'b1, 16'h2144, 1'b0, 1'b0};
      V[6] = '{16'h0000, 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0};
      V[7] = '{16'h1000, 16'h2000, 1'b0, 1'b0, 16'h3000, 1'b0, 1'b0};
      V[8] = '{16'hF000, 16'h2000, 1'b0, 1'b0, 16'h1000, 1'b1, 1'b0};
      V[9] = '{16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b1};
    end
  endtask

  // Push one beat, then count cycles until the result shows up
  task automatic single(input int i, input string tag);
    int n;
    @(negedge clk);
    chk({tag, ".rdy"}, 32'(o_ready), 32'd1);
    drive(i); in_valid = 1'b1; n = 0;
    do begin @(negedge clk); in_valid = 1'b0; n++; end while (!o_valid && n < 40);
    chk({tag, ".lat"}, n, S);
    chk_res(tag, i);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ni, no, n;
    logic [15:0] held;
    tests = 0; fails = 0; cfg = 2'd0;
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0; carry_in = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state of all three instances
    for (int c = 0; c < 3; c++) begin
      cfg = 2'(c); #1;
      chk("rst.valid", 32'(o_valid), 32'd0);
      chk("rst.sum",   32'(o_sum),   32'd0);
      chk("rst.cout",  32'(o_cout),  32'd0);
      chk("rst.ovf",   32'(o_ovf),   32'd0);
      chk("rst.ready", 32'(o_ready), 32'd1);
    end
    rstn = 1'b1;

    for (int c = 0; c < 3; c++) begin
      cfg = 2'(c);
      S = (c == 0) ? 2 : (c == 1) ? 1 : 4;
      load(c == 2);

      // Single beats: carry out, overflow both ways, subtract, boundary carry
      for (int i = 0; i < 6; i++) single(i, $sformatf("single%0d", i));

      // Back-to-back: four beats, four consecutive valid cycles, in order
      for (int k = 0; k <= S + 4; k++) begin
        @(negedge clk);
        chk("b2b.valid", 32'(o_valid), 32'(k >= S && k < S + 4));
        if (k >= S && k < S + 4) chk_res($sformatf("b2b%0d", k - S), 6 + k - S);
        if (k < 4) begin drive(6 + k); in_valid = 1'b1; end
        else in_valid = 1'b0;
      end

      // Stall for 3 cycles with a full pipeline, then drain
      ni = 0; no = 0; held = '0;
      for (int k = 0; k < 80 && no < 6; k++) begin
        @(negedge clk);
        out_ready = !(k >= S + 1 && k < S + 4);
        #1;
        if (k >= S + 1 && k < S + 4) begin
          chk("stall.in_ready", 32'(o_ready), 32'd0);
          chk("stall.valid",    32'(o_valid), 32'd1);
          if (k == S + 1) held = o_sum;
          else chk("stall.hold", 32'(o_sum), 32'(held));
        end
        if (o_valid && out_ready) begin
          chk("stall.extra", 32'(no < 6), 32'd1);
          if (no < 6) chk_res($sformatf("stall%0d", no), no);
          no++;
        end
        if (ni < 6) begin drive(ni); in_valid = 1'b1; end
        else in_valid = 1'b0;
        if (in_valid && o_ready) ni++;
      end
      chk("stall.count", no, 6);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (S + 1) begin
        @(negedge clk);
        chk("stall.tail", 32'(o_valid), 32'd0);
      end

      // Reset mid-flight, then accept a beat on the first edge after release
      @(negedge clk); drive(0); in_valid = 1'b1;
      @(negedge clk); drive(1);
      @(negedge clk); in_valid = 1'b0; rstn = 1'b0;
      @(negedge clk);
      chk("rmid.valid", 32'(o_valid), 32'd0);
      chk("rmid.sum",   32'(o_sum),   32'd0);
      chk("rmid.cout",  32'(o_cout),  32'd0);
      chk("rmid.ready", 32'(o_ready), 32'd1);
      rstn = 1'b1; drive(4); in_valid = 1'b1; n = 0;
      do begin @(negedge clk); in_valid = 1'b0; n++; end while (!o_valid && n < 40);
      chk("rmid.lat", n, S);
      chk_res("rmid", 4);
      repeat (S + 2) begin
        @(negedge clk);
        chk("rmid.stale", 32'(o_valid), 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
